traffic_phase_arbiter: RTL and testbench

//  Schedules green time for a four-approach intersection (A..D): picks the next approach from sensor density,

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/traffic_phase_arbiter_phase_select.sv | 50 +++++
 rtl/traffic_phase_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared light codes, FSM state type, approach index type and
//                the density saturation helper for the phase arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

    localparam logic [2:0] LIGHT_RED   = 3'b100;
    localparam logic [2:0] LIGHT_AMBER = 3'b010;
    localparam logic [2:0] LIGHT_GREEN = 3'b001;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_AMBER   = 2'd2
    } state_t;

    typedef logic [1:0] approach_t;
    typedef logic [1:0] dens_t;

    // A density code of 3 is not meaningful on the sensor side; fold it to heavy.
    function automatic dens_t sat_density(input dens_t d);
        return (d == 2'd3) ? 2'd2 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_arbiter_phase_select.sv
// ============================================================================
//  Module      : phase_select
//  Description : Combinational next-approach picker. Starved approaches win
//                first, then highest density; ties go round-robin from
//                cur_phase+1 (which also covers the all-empty idle case).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_select
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int STARVE_LIM = 3
) (
    input  dens_t     [3:0]            dens,
    input  logic      [3:0][CNT_W-1:0] skip,
    input  approach_t                  cur_phase,
    output approach_t                  winner
);

    always_comb begin
        approach_t idx;
        logic      found;
        dens_t     best;
        approach_t starved_w;
        approach_t dense_w;
        idx       = '0;
        found     = 1'b0;
        best      = '0;
        starved_w = cur_phase + 2'd1;
        dense_w   = cur_phase + 2'd1;
        // k = 4 wraps to cur_phase itself, so it is considered last.
        for (int k = 1; k <= 4; k++) begin
            idx = cur_phase + approach_t'(k);
            if (!found && dens[idx] != 2'd0 && skip[idx] == CNT_W'(STARVE_LIM)) begin
                found     = 1'b1;
                starved_w = idx;
            end
            if (dens[idx] > best) begin
                best    = dens[idx];
                dense_w = idx;
            end
        end
        winner = found ? starved_w : dense_w;
    end

endmodule

`default_nettype wire

// File: rtl/traffic_phase_arbiter.sv
// ============================================================================
//  Module      : traffic_phase_arbiter
//  Description : Four-approach intersection phase scheduler with min/max
//                green, amber, all-red clearance and starvation fairness.
//                Optional pedestrian walk support under macro PED_WALK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter int GREEN_MIN  = 10,
    parameter int GREEN_MAX  = 30,
    parameter int AMBER_T    = 3,
    parameter int ALLRED_T   = 1,
    parameter int STARVE_LIM = 3
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef PED_WALK_EN
    input  logic [3:0] ped_req,
    output logic [3:0] walk,
`endif
    input  logic [1:0] dens_a,
    input  logic [1:0] dens_b,
    input  logic [1:0] dens_c,
    input  logic [1:0] dens_d,
    output logic [2:0] light_a,
    output logic [2:0] light_b,
    output logic [2:0] light_c,
    output logic [2:0] light_d,
    output logic [1:0] cur_phase,
    output logic       phase_start
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic      [CNT_W-1:0]   r_timer;
    logic      [CNT_W-1:0]   w_timer_next;
    logic      [CNT_W-1:0]   r_green_cnt;
    approach_t               r_cur;
    logic                    r_phase_start;
    logic      [3:0][CNT_W-1:0] r_skip;
    dens_t     [3:0]         w_raw;
    dens_t     [3:0]         w_eff;
    approach_t               w_winner;
    logic                    w_grant;
    logic                    w_exit;
    logic                    w_walk_busy;
    logic                    w_other_higher;
    logic                    w_other_starved;
    logic                    w_other_req;
    logic      [3:0][2:0]    w_lights;

    assign w_raw = {dens_d, dens_c, dens_b, dens_a};

`ifdef PED_WALK_EN
    logic [3:0] r_ped_pend;
    logic       r_walk_on;
    logic [3:0] w_grant_mask;

    assign w_grant_mask = w_grant ? (4'd1 << w_winner) : 4'd0;
    assign w_walk_busy  = r_walk_on;
    assign walk         = r_walk_on ? (4'd1 << r_cur) : 4'd0;

    // A press arriving during its own walk survives the clear and waits for the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ped_pend <= '0;
            r_walk_on  <= 1'b0;
        end else begin
            r_ped_pend <= (r_ped_pend & ~w_grant_mask) | ped_req;
            if (w_grant)
                r_walk_on <= r_ped_pend[w_winner];
            else if (r_state == ST_GREEN && r_green_cnt >= CNT_W'(GREEN_MIN))
                r_walk_on <= 1'b0;
        end
    end
`else
    assign w_walk_busy = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_eff[i] = sat_density(w_raw[i]);
`ifdef PED_WALK_EN
            if (r_ped_pend[i] && w_eff[i] == 2'd0)
                w_eff[i] = 2'd1;
`endif
        end
    end

    phase_select #(
        .CNT_W      (CNT_W),
        .STARVE_LIM (STARVE_LIM)
    ) u_phase_select (
        .dens      (w_eff),
        .skip      (r_skip),
        .cur_phase (r_cur),
        .winner    (w_winner)
    );

    always_comb begin
        w_other_higher  = 1'b0;
        w_other_starved = 1'b0;
        w_other_req     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (approach_t'(i) != r_cur) begin
                if (w_eff[i] > w_eff[r_cur])
                    w_other_higher = 1'b1;
                if (w_eff[i] != 2'd0)
                    w_other_req = 1'b1;
                if (w_eff[i] != 2'd0 && r_skip[i] == CNT_W'(STARVE_LIM))
                    w_other_starved = 1'b1;
            end
        end
        w_exit = !w_walk_busy &&
                 ((r_green_cnt >= CNT_W'(GREEN_MIN) && (w_other_higher || w_other_starved)) ||
                  (r_green_cnt == CNT_W'(GREEN_MAX) && w_other_req));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ALL_RED;
            r_timer <= CNT_W'(ALLRED_T);
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_grant      = 1'b0;
        case (r_state)
            ST_ALL_RED: begin
                if (r_timer <= CNT_W'(1)) begin
                    w_state_next = ST_GREEN;
                    w_grant      = 1'b1;
                end else begin
                    w_timer_next = r_timer - CNT_W'(1);
                end
            end
            ST_GREEN: begin
                if (w_exit) begin
                    w_state_next = ST_AMBER;
                    w_timer_next = CNT_W'(AMBER_T);
                end
            end
            ST_AMBER: begin
                if (r_timer <= CNT_W'(1)) begin
                    w_state_next = ST_ALL_RED;
                    w_timer_next = CNT_W'(ALLRED_T);
                end else begin
                    w_timer_next = r_timer - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_ALL_RED;
                w_timer_next = CNT_W'(ALLRED_T);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur         <= 2'd3;
            r_green_cnt   <= '0;
            r_phase_start <= 1'b0;
            r_skip        <= '0;
        end else begin
            r_phase_start <= w_grant;
            if (w_grant) begin
                r_cur       <= w_winner;
                r_green_cnt <= CNT_W'(1);
                for (int i = 0; i < 4; i++) begin
                    if (approach_t'(i) == w_winner)
                        r_skip[i] <= '0;
                    else if (w_eff[i] != 2'd0 && r_skip[i] < CNT_W'(STARVE_LIM))
                        r_skip[i] <= r_skip[i] + CNT_W'(1);
                end
            end else if (r_state == ST_GREEN && r_green_cnt < CNT_W'(GREEN_MAX)) begin
                r_green_cnt <= r_green_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_lights = {4{LIGHT_RED}};
        if (r_state == ST_GREEN)
            w_lights[r_cur] = LIGHT_GREEN;
        else if (r_state == ST_AMBER)
            w_lights[r_cur] = LIGHT_AMBER;
    end

    assign light_a     = w_lights[0];
    assign light_b     = w_lights[1];
    assign light_c     = w_lights[2];
    assign light_d     = w_lights[3];
    assign cur_phase   = r_cur;
    assign phase_start = r_phase_start;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
// ============================================================================
//  Module      : tb_traffic_phase_arbiter
//  Description : Directed self-checking bench for traffic_phase_arbiter
//                (pedestrian section active when PED_WALK_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dens_a, dens_b, dens_c, dens_d;
    logic [2:0] light_a, light_b, light_c, light_d;
    logic [1:0] cur_phase;
    logic       phase_start;
`ifdef PED_WALK_EN
    logic [3:0] ped_req;
    logic [3:0] walk;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    traffic_phase_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef PED_WALK_EN
        .ped_req     (ped_req),
        .walk        (walk),
`endif
        .dens_a      (dens_a),
        .dens_b      (dens_b),
        .dens_c      (dens_c),
        .dens_d      (dens_d),
        .light_a     (light_a),
        .light_b     (light_b),
        .light_c     (light_c),
        .light_d     (light_d),
        .cur_phase   (cur_phase),
        .phase_start (phase_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Steps until phase_start is seen; returns the number of edges taken (bounded).
    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            step(1);
            cycles++;
        end while (!phase_start && cycles < 200);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        dens_a = 0; dens_b = 0; dens_c = 0; dens_d = 0;
`ifdef PED_WALK_EN
        ped_req = 4'd0;
`endif
        // Reset state and idle round-robin to A, then rest on A.
        step(2);
        check("rst_light_a", light_a, 3'b100);
        check("rst_light_b", light_b, 3'b100);
        check("rst_light_c", light_c, 3'b100);
        check("rst_light_d", light_d, 3'b100);
        check("rst_cur_phase", cur_phase, 2'd3);
        check("rst_phase_start", phase_start, 1'b0);
`ifdef PED_WALK_EN
        check("rst_walk", walk, 4'd0);
`endif
        rst_n = 1'b1;
        wait_grant(cyc);
        check("idle_latency", cyc, 1);
        check("idle_cur", cur_phase, 2'd0);
        check("idle_light_a", light_a, 3'b001);
        step(1);
        check("idle_pulse_low", phase_start, 1'b0);
        step(40);
        check("idle_rest_a", light_a, 3'b001);
        check("idle_rest_cur", cur_phase, 2'd0);

        // Heavy demand on B arrives at green_cnt 4: amber after green_cnt 10.
        do_reset();
        wait_grant(cyc);
        check("b_first_grant", cyc, 1);
        step(3);
        dens_b = 2'd2;
        step(6);
        check("b_green_at10", light_a, 3'b001);
        step(1);
        check("b_amber_start", light_a, 3'b010);
        check("b_amber_b_red", light_b, 3'b100);
        step(2);
        check("b_amber_end", light_a, 3'b010);
        step(1);
        check("b_allred_a", light_a, 3'b100);
        check("b_allred_b", light_b, 3'b100);
        step(1);
        check("b_green_b", light_b, 3'b001);
        check("b_cur", cur_phase, 2'd1);
        check("b_pulse", phase_start, 1'b1);

        // A heavy (code 3 folds to 2), C light: C starves after 3 skips.
        dens_b = 0; dens_a = 2'd3; dens_c = 2'd1;
        do_reset();
        wait_grant(cyc);
        check("st_g1_lat", cyc, 1);
        check("st_g1_cur", cur_phase, 2'd0);
        wait_grant(cyc);
        check("st_g2_lat", cyc, 34);
        check("st_g2_cur", cur_phase, 2'd0);
        wait_grant(cyc);
        check("st_g3_lat", cyc, 34);
        check("st_g3_cur", cur_phase, 2'd0);
        wait_grant(cyc);
        check("st_g4_lat", cyc, 14);
        check("st_g4_cur", cur_phase, 2'd2);
        check("st_g4_light_c", light_c, 3'b001);
        check("st_g4_light_a", light_a, 3'b100);

        // B and D tied heavy while A is green: B first, then D.
        dens_a = 0; dens_c = 0;
        do_reset();
        wait_grant(cyc);
        dens_b = 2'd2; dens_d = 2'd2;
        wait_grant(cyc);
        check("tie_first_lat", cyc, 14);
        check("tie_first_cur", cur_phase, 2'd1);
        wait_grant(cyc);
        check("tie_second_lat", cyc, 34);
        check("tie_second_cur", cur_phase, 2'd3);

        // Asynchronous reset during amber.
        dens_b = 0; dens_d = 0;
        do_reset();
        wait_grant(cyc);
        dens_b = 2'd2;
        step(10);
        check("ar_in_amber", light_a, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_light_a", light_a, 3'b100);
        check("ar_light_b", light_b, 3'b100);
        check("ar_cur", cur_phase, 2'd3);
        dens_b = 0;
        step(1);
        rst_n = 1'b1;
        wait_grant(cyc);
        check("ar_restart_lat", cyc, 1);
        check("ar_restart_cur", cur_phase, 2'd0);
        dens_b = 2'd2;
        wait_grant(cyc);
        check("ar_cnt_cleared", cyc, 14);
        check("ar_next_cur", cur_phase, 2'd1);
        dens_b = 0;

`ifdef PED_WALK_EN
        // Pedestrian request on C with no vehicle demand.
        do_reset();
        wait_grant(cyc);
        ped_req = 4'b0100;
        step(1);
        ped_req = 4'd0;
        wait_grant(cyc);
        check("ped_lat", cyc, 13);
        check("ped_cur", cur_phase, 2'd2);
        check("ped_walk_on", walk, 4'b0100);
        step(9);
        check("ped_walk_last", walk, 4'b0100);
        step(1);
        check("ped_walk_off", walk, 4'd0);
        step(30);
        check("ped_rest_cur", cur_phase, 2'd2);
        check("ped_rest_light", light_c, 3'b001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
